// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, req/ack instruction memory fetch, IF/ID register
// with stall hold buffer, redirect flush, and drain of abandoned in-flight requests.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] drain_addr_reg;
  logic [31:0] buf_instr_reg;
  logic [31:0] buf_pc4_reg;
  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;

  logic [31:0] pc_next;
  logic [31:0] redirect_aligned;
  logic [31:0] reset_pc_aligned;

  assign pc_next          = pc_reg + 32'd4;
  assign redirect_aligned = redirect_pc & ~32'h3;
  assign reset_pc_aligned = RESET_PC & ~32'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= reset_pc_aligned;
      drain_addr_reg <= 32'h0;
      buf_instr_reg  <= 32'h0;
      buf_pc4_reg    <= 32'h0;
      valid_reg      <= 1'b0;
      instr_reg      <= 32'h0;
      pc4_reg        <= 32'h0;
    end else if (redirect) begin
      pc_reg        <= redirect_aligned;
      valid_reg     <= 1'b0;
      instr_reg     <= 32'h0;
      buf_instr_reg <= 32'h0;
      buf_pc4_reg   <= 32'h0;
      case (state_reg)
        // An unacknowledged request must stay on the bus until memory answers it.
        FETCH: begin
          if (imem_ack) begin
            state_reg <= FETCH;
          end else begin
            state_reg      <= DRAIN;
            drain_addr_reg <= pc_reg;
          end
        end
        DRAIN:   state_reg <= imem_ack ? FETCH : DRAIN;
        default: state_reg <= FETCH;
      endcase
    end else begin
      case (state_reg)
        IDLE: state_reg <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc_reg <= pc_next;
            if (stall) begin
              buf_instr_reg <= imem_rdata;
              buf_pc4_reg   <= pc_next;
              state_reg     <= HOLD;
            end else begin
              valid_reg <= 1'b1;
              instr_reg <= imem_rdata;
              pc4_reg   <= pc_next;
            end
          end else if (!stall) begin
            valid_reg <= 1'b0;
            instr_reg <= 32'h0;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_reg     <= 1'b1;
            instr_reg     <= buf_instr_reg;
            pc4_reg       <= buf_pc4_reg;
            buf_instr_reg <= 32'h0;
            buf_pc4_reg   <= 32'h0;
            state_reg     <= FETCH;
          end
        end
        DRAIN: begin
          valid_reg <= 1'b0;
          instr_reg <= 32'h0;
          if (imem_ack) state_reg <= FETCH;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state_reg == FETCH) || (state_reg == DRAIN);
  assign imem_addr   = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
  assign if_id_valid = valid_reg;
  assign if_id_instr = instr_reg;
  assign if_id_pc4   = pc4_reg;
  assign opcode      = valid_reg ? instr_reg[31:26] : 6'd0;

endmodule
